// File: rtl/dcache_mem.sv
// dcache_mem: dcache line-transfer sequencer for a quad-SPI PSRAM.
// Optional VC32_PSRAM_QPI_INIT_EN: send QPI-enable (0x35) in SPI mode after reset.
module dcache_mem #(
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  parameter int WAIT        = 6,
  parameter int CS_GAP      = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pull,
  input  logic          push,
  input  logic [PA-3:0] pull_tag,
  input  logic [PA-3:0] push_tag,
  input  logic [3:0]    dwrite,
  output logic          rstrobe_d,
  output logic          wstrobe_d,
  output logic [3:0]    dread,
  output logic          busy,
  output logic          done,
  output logic          mem_cs_n,
  output logic          mem_sck_en,
  output logic          mem_oe,
  output logic [3:0]    mem_out,
  input  logic [3:0]    mem_in
);

  localparam int NIB = 2 * LINE_LENGTH;
  localparam logic [7:0] QPI_CMD = 8'h35;

  typedef enum logic [3:0] {
    IDLE, WB_GATHER, WB_CMD, WB_ADDR, WB_DATA, GAP,
    RD_CMD, RD_ADDR, RD_DUMMY, RD_DATA, FILL, DONE, INIT
  } state_t;

`ifdef VC32_PSRAM_QPI_INIT_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t state, state_n, nxt;
  logic [3:0] cnt, cnt_n, lim;
  logic [PA-3:0] tag;
  logic [31:0] lbuf;
  logic [23:0] addr24;
  logic [2:0] c, ai;
  logic cs_n_n, sck_n, oe_n, rs_n, ws_n, done_n;
  logic [3:0] out_n, dr_n;

  assign addr24 = {{(24-PA){1'b0}}, tag, 2'b00};
  assign c      = cnt_n[2:0];
  assign ai     = 3'd5 - c;

  // Next state: each state lasts lim+1 cycles, IDLE waits for pull.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 4'd1;
    lim     = 4'd0;
    nxt     = IDLE;
    unique case (state)
      IDLE:      nxt = push ? WB_GATHER : RD_CMD;
      WB_GATHER: begin lim = 4'(NIB-1);    nxt = WB_CMD;   end
      WB_CMD:    begin lim = 4'd1;         nxt = WB_ADDR;  end
      WB_ADDR:   begin lim = 4'd5;         nxt = WB_DATA;  end
      WB_DATA:   begin lim = 4'(NIB-1);    nxt = GAP;      end
      GAP:       begin lim = 4'(CS_GAP-1); nxt = RD_CMD;   end
      RD_CMD:    begin lim = 4'd1;         nxt = RD_ADDR;  end
      RD_ADDR:   begin lim = 4'd5;         nxt = RD_DUMMY; end
      RD_DUMMY:  begin lim = 4'(WAIT-1);   nxt = RD_DATA;  end
      RD_DATA:   begin lim = 4'(NIB-1);    nxt = FILL;     end
      FILL:      begin lim = 4'(NIB-1);    nxt = DONE;     end
      DONE:      begin lim = 4'd0;         nxt = IDLE;     end
      INIT:      begin lim = 4'd9;         nxt = IDLE;     end
      default:   begin lim = 4'd0;         nxt = IDLE;     end
    endcase
    if (state == IDLE) begin
      cnt_n = 4'd0;
      if (pull) state_n = nxt;
    end else if (cnt == lim) begin
      cnt_n   = 4'd0;
      state_n = nxt;
    end
  end

  // Output decode from the upcoming state so every output is a register.
  always_comb begin
    cs_n_n = 1'b1;
    sck_n  = 1'b0;
    oe_n   = 1'b0;
    out_n  = 4'h0;
    rs_n   = 1'b0;
    ws_n   = 1'b0;
    dr_n   = 4'h0;
    done_n = 1'b0;
    unique case (state_n)
      WB_GATHER: rs_n = 1'b1;
      WB_CMD: begin
        cs_n_n = 1'b0; sck_n = 1'b1; oe_n = 1'b1;
        out_n  = (c == 3'd0) ? 4'h3 : 4'h8;
      end
      WB_ADDR, RD_ADDR: begin
        cs_n_n = 1'b0; sck_n = 1'b1; oe_n = 1'b1;
        out_n  = addr24[{ai, 2'b00} +: 4];
      end
      WB_DATA: begin
        cs_n_n = 1'b0; sck_n = 1'b1; oe_n = 1'b1;
        out_n  = lbuf[{c ^ 3'd1, 2'b00} +: 4];
      end
      RD_CMD: begin
        cs_n_n = 1'b0; sck_n = 1'b1; oe_n = 1'b1;
        out_n  = (c == 3'd0) ? 4'hE : 4'hB;
      end
      RD_DUMMY, RD_DATA: begin
        cs_n_n = 1'b0; sck_n = 1'b1;
      end
      FILL: begin
        ws_n = 1'b1;
        dr_n = lbuf[{c, 2'b00} +: 4];
      end
      DONE: done_n = 1'b1;
      INIT: begin
        if (cnt_n != 4'd0 && cnt_n <= 4'd8) begin
          cs_n_n = 1'b0; sck_n = 1'b1; oe_n = 1'b1;
          out_n  = {3'b000, QPI_CMD[3'(4'd8 - cnt_n)]};
        end
      end
      default: ;
    endcase
  end

  // State and per-state cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST_STATE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Line address and nibble buffer; memory order is buffer nibble k^1.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag  <= '0;
      lbuf <= '0;
    end else begin
      if (state == IDLE && pull)
        tag <= push ? push_tag : pull_tag;
      if (state == GAP && state_n == RD_CMD)
        tag <= pull_tag;
      if (state == WB_GATHER)
        lbuf[{cnt[2:0], 2'b00} +: 4] <= dwrite;
      if (state == RD_DATA)
        lbuf[{cnt[2:0] ^ 3'd1, 2'b00} +: 4] <= mem_in;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_cs_n   <= 1'b1;
      mem_sck_en <= 1'b0;
      mem_oe     <= 1'b0;
      mem_out    <= 4'h0;
      rstrobe_d  <= 1'b0;
      wstrobe_d  <= 1'b0;
      dread      <= 4'h0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_cs_n   <= cs_n_n;
      mem_sck_en <= sck_n;
      mem_oe     <= oe_n;
      mem_out    <= out_n;
      rstrobe_d  <= rs_n;
      wstrobe_d  <= ws_n;
      dread      <= dr_n;
      done       <= done_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_dcache_mem.sv
// tb_dcache_mem: directed bench for dcache_mem.
// Includes an INIT scenario when VC32_PSRAM_QPI_INIT_EN is defined.
module tb_dcache_mem;

  localparam int W = 6;
  localparam int G = 1;

  logic clk = 1'b0;
  logic reset, pull, push;
  logic [19:0] pull_tag, push_tag;
  logic [3:0] dwrite, dread, mem_out, mem_in;
  logic rstrobe_d, wstrobe_d, busy, done;
  logic mem_cs_n, mem_sck_en, mem_oe;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] rd_data = 32'h0;

  dcache_mem #(.PA(22), .LINE_LENGTH(4), .WAIT(W), .CS_GAP(G)) dut (
    .clk(clk), .reset(reset), .pull(pull), .push(push),
    .pull_tag(pull_tag), .push_tag(push_tag), .dwrite(dwrite),
    .rstrobe_d(rstrobe_d), .wstrobe_d(wstrobe_d), .dread(dread),
    .busy(busy), .done(done), .mem_cs_n(mem_cs_n),
    .mem_sck_en(mem_sck_en), .mem_oe(mem_oe), .mem_out(mem_out),
    .mem_in(mem_in)
  );

  always #5 clk = ~clk;

  // PSRAM model: on a read (first nibble E) return rd_data bytes, high nibble first.
  int pos = 0;
  logic rd_txn = 1'b0;
  always @(negedge clk) begin
    if (mem_cs_n) begin
      pos = 0;
      mem_in = 4'h0;
    end else begin
      if (pos == 0) rd_txn = (mem_out == 4'hE);
      if (rd_txn && pos >= 8 + W && pos < 16 + W)
        mem_in = rd_data[28 - 4 * (pos - 8 - W) +: 4];
      else
        mem_in = 4'h0;
      pos++;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step(); step();
    compared++;
    if (mem_cs_n !== 1'b1 || mem_sck_en !== 1'b0 || mem_oe !== 1'b0 || mem_out !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_mem got cs_n=%b sck=%b oe=%b out=%h exp 1 0 0 0",
               mem_cs_n, mem_sck_en, mem_oe, mem_out);
    end
    compared++;
    if (rstrobe_d !== 1'b0 || wstrobe_d !== 1'b0 || dread !== 4'h0 || done !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_cache got rs=%b ws=%b dread=%h done=%b busy=%b exp all 0",
               rstrobe_d, wstrobe_d, dread, done, busy);
    end
    reset = 1'b0;
  endtask

`ifdef VC32_PSRAM_QPI_INIT_EN
  task automatic test_init();
    logic [7:0] bits = 8'h35;
    pull_tag = 20'h12345;
    rd_data = 32'hA1B2C3D4;
    pull = 1'b1;
    for (int n = 1; n <= 43; n++) begin
      step();
      if (n <= 8) begin
        compared++;
        if (mem_out[0] !== bits[8-n] || mem_cs_n !== 1'b0 || mem_oe !== 1'b1) begin
          mismatched++;
          $display("FAIL init_bit c%0d got out0=%b cs_n=%b oe=%b exp %b 0 1",
                   n, mem_out[0], mem_cs_n, mem_oe, bits[8-n]);
        end
      end
      if (n == 9) begin
        compared++;
        if (mem_cs_n !== 1'b1 || busy !== 1'b1) begin
          mismatched++;
          $display("FAIL init_gap got cs_n=%b busy=%b exp 1 1", mem_cs_n, busy);
        end
      end
      if (n == 10) begin
        compared++;
        if (busy !== 1'b0 || mem_cs_n !== 1'b1) begin
          mismatched++;
          $display("FAIL init_idle got busy=%b cs_n=%b exp 0 1", busy, mem_cs_n);
        end
      end
      if (n == 11) begin
        compared++;
        if (mem_out !== 4'hE || mem_cs_n !== 1'b0) begin
          mismatched++;
          $display("FAIL init_first_cmd got out=%h cs_n=%b exp e 0", mem_out, mem_cs_n);
        end
      end
      compared++;
      if (done !== (n == 41)) begin
        mismatched++;
        $display("FAIL init_done c%0d got %b exp %b", n, done, n == 41);
      end
      if (n == 41) pull = 1'b0;
    end
  endtask
`endif

  task automatic test_fill();
    logic [3:0] eo [8] = '{4'hE, 4'hB, 4'h0, 4'h4, 4'h8, 4'hD, 4'h1, 4'h4};
    logic [3:0] ed [8] = '{4'h1, 4'hA, 4'h2, 4'hB, 4'h3, 4'hC, 4'h4, 4'hD};
    logic ex;
    pull_tag = 20'h12345;
    rd_data = 32'hA1B2C3D4;
    pull = 1'b1;
    push = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      step();
      ex = (n <= 16 + W);
      compared++;
      if (mem_cs_n !== !ex || mem_sck_en !== ex) begin
        mismatched++;
        $display("FAIL fill_cs c%0d got cs_n=%b sck=%b exp %b %b", n, mem_cs_n, mem_sck_en, !ex, ex);
      end
      if (n <= 8) begin
        compared++;
        if (mem_out !== eo[n-1] || mem_oe !== 1'b1) begin
          mismatched++;
          $display("FAIL fill_cmd_addr c%0d got out=%h oe=%b exp %h 1", n, mem_out, mem_oe, eo[n-1]);
        end
      end
      if (n >= 9 && n <= 8 + W) begin
        compared++;
        if (mem_out !== 4'h0 || mem_oe !== 1'b0) begin
          mismatched++;
          $display("FAIL fill_dummy c%0d got out=%h oe=%b exp 0 0", n, mem_out, mem_oe);
        end
      end
      ex = (n >= 17 + W && n <= 24 + W);
      compared++;
      if (wstrobe_d !== ex || rstrobe_d !== 1'b0) begin
        mismatched++;
        $display("FAIL fill_wstrobe c%0d got ws=%b rs=%b exp %b 0", n, wstrobe_d, rstrobe_d, ex);
      end
      if (ex) begin
        compared++;
        if (dread !== ed[n-17-W]) begin
          mismatched++;
          $display("FAIL fill_dread c%0d got %h exp %h", n, dread, ed[n-17-W]);
        end
      end
      compared++;
      if (done !== (n == 25 + W) || busy !== (n <= 25 + W)) begin
        mismatched++;
        $display("FAIL fill_done_busy c%0d got done=%b busy=%b exp %b %b",
                 n, done, busy, n == 25 + W, n <= 25 + W);
      end
      if (n == 25 + W) pull = 1'b0;
    end
  endtask

  task automatic test_writeback();
    logic [3:0] ew [16] = '{4'h3, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0,
                            4'h1, 4'h0, 4'h3, 4'h2, 4'h5, 4'h4, 4'h7, 4'h6};
    logic [3:0] er [8] = '{4'hE, 4'hB, 4'h0, 4'h4, 4'h8, 4'hD, 4'h1, 4'h4};
    logic [3:0] ed [8] = '{4'hA, 4'h5, 4'hB, 4'h6, 4'hC, 4'h7, 4'hD, 4'h8};
    logic ex;
    push_tag = 20'h00010;
    pull_tag = 20'h12345;
    rd_data = 32'h5A6B7C8D;
    push = 1'b1;
    pull = 1'b1;
    for (int n = 1; n <= 58; n++) begin
      step();
      dwrite = (n <= 8) ? 4'(n - 1) : 4'hF;
      compared++;
      if (rstrobe_d !== (n <= 8)) begin
        mismatched++;
        $display("FAIL wb_rstrobe c%0d got %b exp %b", n, rstrobe_d, n <= 8);
      end
      ex = (n >= 9 && n <= 24) || (n >= 25 + G && n <= 40 + G + W);
      compared++;
      if (mem_cs_n !== !ex) begin
        mismatched++;
        $display("FAIL wb_cs c%0d got %b exp %b", n, mem_cs_n, !ex);
      end
      if (n >= 9 && n <= 24) begin
        compared++;
        if (mem_out !== ew[n-9] || mem_oe !== 1'b1) begin
          mismatched++;
          $display("FAIL wb_out c%0d got out=%h oe=%b exp %h 1", n, mem_out, mem_oe, ew[n-9]);
        end
      end
      if (n >= 25 + G && n <= 32 + G) begin
        compared++;
        if (mem_out !== er[n-25-G] || mem_oe !== 1'b1) begin
          mismatched++;
          $display("FAIL wb_rd_cmd c%0d got out=%h oe=%b exp %h 1", n, mem_out, mem_oe, er[n-25-G]);
        end
      end
      ex = (n >= 41 + G + W && n <= 48 + G + W);
      compared++;
      if (wstrobe_d !== ex) begin
        mismatched++;
        $display("FAIL wb_wstrobe c%0d got %b exp %b", n, wstrobe_d, ex);
      end
      if (ex) begin
        compared++;
        if (dread !== ed[n-41-G-W]) begin
          mismatched++;
          $display("FAIL wb_dread c%0d got %h exp %h", n, dread, ed[n-41-G-W]);
        end
      end
      compared++;
      if (done !== (n == 49 + G + W)) begin
        mismatched++;
        $display("FAIL wb_done c%0d got %b exp %b", n, done, n == 49 + G + W);
      end
      if (n == 49 + G + W) begin
        pull = 1'b0;
        push = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    pull_tag = 20'h12345;
    rd_data = 32'hA1B2C3D4;
    pull = 1'b1;
    for (int n = 1; n <= 12; n++) step();
    reset = 1'b1;
    pull = 1'b0;
    step();
    compared++;
    if (mem_cs_n !== 1'b1 || busy !== 1'b0 || rstrobe_d !== 1'b0 || wstrobe_d !== 1'b0 || mem_oe !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset got cs_n=%b busy=%b rs=%b ws=%b oe=%b exp 1 0 0 0 0",
               mem_cs_n, busy, rstrobe_d, wstrobe_d, mem_oe);
    end
    reset = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      step();
      compared++;
      if (mem_cs_n !== 1'b1 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL midreset_idle c%0d got cs_n=%b busy=%b exp 1 0", n, mem_cs_n, busy);
      end
    end
    test_fill();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea [6] = '{4'h0, 4'h0, 4'h2, 4'hA, 4'hF, 4'h0};
    logic [3:0] ed [8] = '{4'hF, 4'h0, 4'hE, 4'h1, 4'hD, 4'h2, 4'hC, 4'h3};
    logic ex;
    int dones = 0;
    int gap = 0;
    pull_tag = 20'h12345;
    rd_data = 32'hA1B2C3D4;
    pull = 1'b1;
    push = 1'b0;
    for (int n = 1; n <= 66; n++) begin
      step();
      if (done === 1'b1) dones++;
      if (n > 16 + W && n < 33 && mem_cs_n === 1'b1) gap++;
      ex = (n <= 16 + W) || (n >= 33 && n <= 48 + W);
      compared++;
      if (mem_cs_n !== !ex) begin
        mismatched++;
        $display("FAIL b2b_cs c%0d got %b exp %b", n, mem_cs_n, !ex);
      end
      if (n >= 35 && n <= 40) begin
        compared++;
        if (mem_out !== ea[n-35]) begin
          mismatched++;
          $display("FAIL b2b_addr2 c%0d got %h exp %h", n, mem_out, ea[n-35]);
        end
      end
      if (n >= 49 + W && n <= 56 + W) begin
        compared++;
        if (wstrobe_d !== 1'b1 || dread !== ed[n-49-W]) begin
          mismatched++;
          $display("FAIL b2b_fill2 c%0d got ws=%b dread=%h exp 1 %h", n, wstrobe_d, dread, ed[n-49-W]);
        end
      end
      compared++;
      if (done !== (n == 25 + W || n == 57 + W)) begin
        mismatched++;
        $display("FAIL b2b_done c%0d got %b exp %b", n, done, n == 25 + W || n == 57 + W);
      end
      if (n == 25 + W) begin
        pull_tag = 20'h00ABC;
        rd_data = 32'h0F1E2D3C;
      end
      if (n == 57 + W) pull = 1'b0;
    end
    compared++;
    if (dones !== 2) begin
      mismatched++;
      $display("FAIL b2b_done_count got %0d exp 2", dones);
    end
    compared++;
    if (gap < 2) begin
      mismatched++;
      $display("FAIL b2b_cs_gap got %0d exp >=2", gap);
    end
  endtask

  task automatic test_push_only();
    push_tag = 20'h00010;
    push = 1'b1;
    pull = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      compared++;
      if (busy !== 1'b0 || mem_cs_n !== 1'b1 || rstrobe_d !== 1'b0) begin
        mismatched++;
        $display("FAIL push_only c%0d got busy=%b cs_n=%b rs=%b exp 0 1 0", n, busy, mem_cs_n, rstrobe_d);
      end
    end
    push = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pull = 1'b0;
    push = 1'b0;
    pull_tag = '0;
    push_tag = '0;
    dwrite = 4'h0;
    @(negedge clk);
    test_reset();
`ifdef VC32_PSRAM_QPI_INIT_EN
    test_init();
`endif
    test_fill();
    test_writeback();
    test_reset_mid();
    test_back_to_back();
    test_push_only();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dcache_mem.md
# dcache_mem

Line-transfer sequencer between `dcache` and an external quad-SPI PSRAM.
- On a cache miss it optionally writes back the dirty victim line, then fetches the missing line.
- Toward the cache it drives the nibble streams: `rstrobe_d` with `dwrite`, and `wstrobe_d` with `dread`.
- Toward the PSRAM it drives QPI commands on a 4-bit bus.
- An internal 32-bit line buffer converts between the cache's ascending-nibble order and the memory's high-nibble-first byte order.

## Interface
Parameters:
- `PA`, 22, physical address width.
- `LINE_LENGTH`, 4, bytes per line; only 4 is supported, giving NIB = 8 nibbles per line.
- `WAIT`, 6, read dummy cycles (1..15).
- `CS_GAP`, 1, minimum cycles `mem_cs_n` stays high between transactions (1..7).

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `pull`  in  1  level; line fetch required.
- `push`  in  1  level; dirty victim writeback required first.
- `pull_tag`  in  PA-2  line address to fetch, `paddr[PA-1:2]`.
- `push_tag`  in  PA-2  victim line address.
- `dwrite`  in  4  victim nibble from the cache, valid during `rstrobe_d`.
- `rstrobe_d`  out  1  cache read strobe.
- `wstrobe_d`  out  1  cache fill strobe.
- `dread`  out  4  fill nibble, valid during `wstrobe_d`.
- `busy`  out  1  high whenever the sequencer is not in IDLE.
- `done`  out  1  one-cycle pulse when a fill completes.
- `mem_cs_n`  out  1  PSRAM chip select.
- `mem_sck_en`  out  1  PSRAM clock gate enable.
- `mem_oe`  out  1  `mem_out` drive enable.
- `mem_out`  out  4  PSRAM data out.
- `mem_in`  in  4  PSRAM data in.

## Operation
States: IDLE, WB_GATHER, WB_CMD, WB_ADDR, WB_DATA, GAP, RD_CMD, RD_ADDR, RD_DUMMY, RD_DATA, FILL, DONE; plus INIT when the macro below is defined. A 4-bit counter `cnt` runs within each state.

**IDLE**
- Samples `pull` and `push`.
- `push`=1 → latch `push_tag` into the address register, go to WB_GATHER.
- Otherwise, `pull`=1 → latch `pull_tag`, go to RD_CMD.
- `push` is ignored without `pull`.
- `pull_tag` is re-latched on leaving GAP after a writeback.

**WB_GATHER (8 cycles)**
- `rstrobe_d`=1 for exactly 8 consecutive cycles.
- Cycle k writes `dwrite` into buffer nibble k.

**WB_CMD / RD_CMD (2 cycles)**
- `mem_out` = 0x3 then 0x8 for write; 0xE then 0xB for read.

**WB_ADDR / RD_ADDR (6 cycles)**
- 24-bit byte address {zero-extend, tag, 2'b00}, most-significant nibble first.

**WB_DATA (8 cycles)**
- Bytes 0..3 in order, high nibble then low nibble of each byte.
- Wire order is buffer nibble 1,0,3,2,5,4,7,6.
- After the last nibble → GAP.

**RD_DUMMY (WAIT cycles)**
- `mem_oe`=0, `mem_out`=0.

**RD_DATA (8 cycles)**
- `mem_in` is sampled each cycle into buffer nibbles 1,0,3,2,5,4,7,6.

**FILL (8 cycles)**
- `wstrobe_d`=1 for 8 consecutive cycles; `dread` = buffer nibble k in cycle k.
- The cache's offset counter requires the strobes to be contiguous.

**DONE (1 cycle)**
- `done`=1, then → IDLE.
- The cache line becomes valid on the last FILL edge, so `pull` is already low by the next IDLE.

**GAP**
- `mem_cs_n`=1 for CS_GAP cycles, then → RD_CMD.

**Chip-select and output-enable rules**
- `mem_cs_n`=0 and `mem_sck_en`=1 in CMD, ADDR, DUMMY, DATA states only.
- `mem_oe`=1 in WB_CMD, WB_ADDR, WB_DATA, RD_CMD, RD_ADDR.

**Reset values:** state = IDLE (or INIT), `mem_cs_n`=1, `mem_sck_en`=0, `mem_oe`=0, `mem_out`=0, `rstrobe_d`=0, `wstrobe_d`=0, `dread`=0, `done`=0, `busy`=0.

**Reset mid-transfer**
- IDLE on the next edge; `cs_n` high and strobes low from that edge.
- Partial buffer contents are discarded.

## Timing
- All outputs are registered.
- Fill only: with `pull` seen in IDLE cycle 0:
  - `mem_cs_n` low cycles 1..16+WAIT.
  - `wstrobe_d` high cycles 17+WAIT..24+WAIT.
  - `done` in cycle 25+WAIT (31 at WAIT=6).
- Writeback+fill:
  - `rstrobe_d` cycles 1..8.
  - Write burst cycles 9..24.
  - GAP cycles 25..24+CS_GAP.
  - Read command starts in cycle 25+CS_GAP.
  - `done` in cycle 49+CS_GAP+WAIT (56 with defaults).
- Back-to-back requests: `pull` is resampled in the IDLE cycle after DONE. Minimum `cs_n`-high time is therefore ≥2 cycles between a fill and the next request.

## Configuration
`VC32_PSRAM_QPI_INIT_EN`:
- **Defined:** reset enters INIT, which sends command 0x35 in SPI mode.
  - 8 cycles on `mem_out[0]`, MSB first; `mem_oe`=1, `mem_cs_n`=0.
  - Then one `cs_n`-high cycle, then IDLE.
  - `busy`=1 throughout INIT; requests are ignored until IDLE.
- **Undefined:** reset goes directly to IDLE and the PSRAM is assumed already in QPI mode.

## Test plan
- **Fill:** `pull`=1, `pull_tag`=0x12345, WAIT=6, memory returns bytes 0xA1,0xB2,0xC3,0xD4 → address nibbles 0,4,8,D,1,4; `dread` sequence 1,A,2,B,3,C,4,D on 8 contiguous `wstrobe_d` cycles; `done` at cycle 31.
- **Writeback+fill:** `push`=1, `push_tag`=0x00010, `dwrite` sequence 0..7 → `mem_out` 3,8,0,0,0,0,4,0 then 1,0,3,2,5,4,7,6; `cs_n` high for CS_GAP cycles; then read of `pull_tag`; `done` at cycle 56.
- **Reset mid-transfer:** assert `reset` in RD_DUMMY → next edge `cs_n`=1, `busy`=0, no strobes; a following `pull` runs a clean fill.
- **Back-to-back:** `pull` held for two different tags → two complete fills; `done` pulses exactly once each; `cs_n` high ≥2 cycles between them.
- **Push without pull:** no transaction, `busy` stays 0.
- **With `VC32_PSRAM_QPI_INIT_EN`:** after reset, `mem_out[0]` serial 0,0,1,1,0,1,0,1 on 8 cycles; a `pull` during INIT is ignored until IDLE.
